led_status_ctrl: RTL and testbench

// - Parametrised successor to the free-running-counter LED/PMOD heartbeats in onetswitch_top.
// - NUM_CH independent indicator channels. Each channel is OFF, ON, BLINK (programmable

---
 rtl/led_status_ctrl_pkg.sv | 22 ++
 rtl/led_status_ctrl_if.sv | 20 ++
 rtl/led_status_ctrl_chan.sv | 78 +++++++
 rtl/led_status_ctrl.sv | 71 +++++++
 tb/tb_led_status_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_status_ctrl_pkg.sv
// Shared types and helpers for the LED status controller: mode encoding and
// the channel-select width rule.
package led_status_pkg;

  typedef enum logic [1:0] {
    LED_OFF   = 2'b00,
    LED_ON    = 2'b01,
    LED_BLINK = 2'b10,
    LED_ACT   = 2'b11
  } led_mode_t;

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_ACT   = 2'b11;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_status_ctrl_if.sv
// Configuration write bus for led_status_ctrl: one-cycle strobe plus target
// channel, mode and blink half-period.
interface led_status_ctrl_if
  import led_status_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int PER_W  = 10
) ();

  localparam int CH_W = ch_width(NUM_CH);

  logic             cfg_wr;
  logic [CH_W-1:0]  cfg_ch;
  led_mode_t        cfg_mode;
  logic [PER_W-1:0] cfg_half_per;

  modport master (output cfg_wr, cfg_ch, cfg_mode, cfg_half_per);
  modport slave  (input  cfg_wr, cfg_ch, cfg_mode, cfg_half_per);

endinterface

// File: rtl/led_status_ctrl_chan.sv
// One indicator channel: holds its mode and half-period, runs the blink
// counter/phase and the activity pulse stretcher, and presents the raw state.
module led_status_chan
  import led_status_pkg::*;
#(
  parameter int PER_W         = 10,
  parameter int DEF_HALF_PER  = 500,
  parameter int STRETCH_TICKS = 50
) (
  input  logic             bd_fclk0_125m,
  input  logic             ext_rst_n,
  input  logic             tick,
  input  logic             act_evt,
  input  logic             load,
  input  led_mode_t        cfg_mode,
  input  logic [PER_W-1:0] cfg_half_per,
  output logic             raw
);

  localparam int ST_W = $clog2(STRETCH_TICKS + 1);

  led_mode_t        mode;
  logic [PER_W-1:0] half_per;
  logic [PER_W-1:0] blk_cnt;
  logic [PER_W-1:0] blk_last;
  logic             phase;
  logic [ST_W-1:0]  stretch;

  // A zero half-period blinks as if it were one tick.
  assign blk_last = (half_per == '0) ? '0 : half_per - 1'b1;

  // NOTE: reset is sampled on the clock edge and every register here is
  // updated with <= so all flops see pre-edge values of each other.
  always_ff @(posedge bd_fclk0_125m) begin
    if (!ext_rst_n) begin
      mode     <= LED_OFF;
      half_per <= PER_W'(DEF_HALF_PER);
      blk_cnt  <= '0;
      phase    <= 1'b0;
      stretch  <= '0;
    end else if (load) begin
      mode     <= cfg_mode;
      half_per <= cfg_half_per;
      blk_cnt  <= '0;
      phase    <= 1'b0;
      stretch  <= '0;
    end else begin
      if (mode == LED_BLINK && tick) begin
        if (blk_cnt == blk_last) begin
          blk_cnt <= '0;
          phase   <= ~phase;
        end else begin
          blk_cnt <= blk_cnt + 1'b1;
        end
      end
      // A new event reloads even on a tick cycle, so sustained events hold on.
      if (mode == LED_ACT) begin
        if (act_evt) begin
          stretch <= ST_W'(STRETCH_TICKS);
        end else if (tick && stretch != '0) begin
          stretch <= stretch - 1'b1;
        end
      end
    end
  end

  always_comb begin
    // NOTE: default assignment first keeps every path driving raw (no latch).
    raw = 1'b0;
    case (mode)
      LED_ON:    raw = 1'b1;
      LED_BLINK: raw = phase;
      LED_ACT:   raw = (stretch != '0);
      default:   raw = 1'b0;
    endcase
  end

endmodule

// File: rtl/led_status_ctrl.sv
// LED/PMOD status controller: shared tick prescaler and PWM brightness
// counter, config decode, and NUM_CH indicator channels with registered drive.
module led_status_ctrl
  import led_status_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int PRESCALE      = 125000,
  parameter int PER_W         = 10,
  parameter int DEF_HALF_PER  = 500,
  parameter int STRETCH_TICKS = 50,
  parameter int PWM_W         = 4
) (
  input  logic                bd_fclk0_125m,
  input  logic                ext_rst_n,
  led_status_ctrl_if.slave    cfg,
  input  logic [NUM_CH-1:0]   act_evt,
  input  logic [PWM_W-1:0]    pwm_duty,
  output logic                tick,
  output logic [NUM_CH-1:0]   led_out
);

  localparam int CH_W  = ch_width(NUM_CH);
  localparam int PRE_W = $clog2(PRESCALE);

  logic [PRE_W-1:0]  pre_cnt;
  logic [PWM_W-1:0]  pwm_cnt;
  logic              pre_wrap;
  logic              pwm_on;
  logic [NUM_CH-1:0] raw;

  assign pre_wrap = (pre_cnt == PRE_W'(PRESCALE - 1));

  // Full-scale duty is solidly lit; zero duty is always dark.
  assign pwm_on = (pwm_cnt < pwm_duty) || (&pwm_duty);

  always_ff @(posedge bd_fclk0_125m) begin
    if (!ext_rst_n) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
      pwm_cnt <= '0;
      led_out <= '0;
    end else begin
      pre_cnt <= pre_wrap ? '0 : pre_cnt + 1'b1;
      tick    <= pre_wrap;
      pwm_cnt <= pwm_cnt + 1'b1;
      led_out <= raw & {NUM_CH{pwm_on}};
    end
  end

  // Out-of-range channel codes match no channel, so such writes are dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic load;
    assign load = cfg.cfg_wr && (cfg.cfg_ch == CH_W'(i));

    led_status_chan #(
      .PER_W         (PER_W),
      .DEF_HALF_PER  (DEF_HALF_PER),
      .STRETCH_TICKS (STRETCH_TICKS)
    ) u_chan (
      .bd_fclk0_125m (bd_fclk0_125m),
      .ext_rst_n     (ext_rst_n),
      .tick          (tick),
      .act_evt       (act_evt[i]),
      .load          (load),
      .cfg_mode      (cfg.cfg_mode),
      .cfg_half_per  (cfg.cfg_half_per),
      .raw           (raw[i])
    );
  end

endmodule

// File: tb/tb_led_status_ctrl.sv
// Self-checking bench for led_status_ctrl: tick-count reference model compared
// every cycle, plus hand-computed directed expectations.
module tb_led_status_ctrl;
  import led_status_pkg::*;

  localparam int NUM_CH        = 4;
  localparam int PRESCALE      = 4;
  localparam int PER_W         = 10;
  localparam int DEF_HALF_PER  = 3;
  localparam int STRETCH_TICKS = 5;
  localparam int PWM_W         = 4;
  localparam int NUM_CH2       = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NUM_CH-1:0] act_evt = '0;
  logic [PWM_W-1:0]  pwm_duty = '0;
  logic              tick;
  logic [NUM_CH-1:0] led_out;

  logic [NUM_CH2-1:0] act_evt2 = '0;
  logic [PWM_W-1:0]   pwm_duty2 = '1;
  logic               tick2;
  logic [NUM_CH2-1:0] led_out2;

  led_status_ctrl_if #(.NUM_CH(NUM_CH),  .PER_W(PER_W)) cfg ();
  led_status_ctrl_if #(.NUM_CH(NUM_CH2), .PER_W(PER_W)) cfg2 ();

  led_status_ctrl #(
    .NUM_CH(NUM_CH), .PRESCALE(PRESCALE), .PER_W(PER_W),
    .DEF_HALF_PER(DEF_HALF_PER), .STRETCH_TICKS(STRETCH_TICKS), .PWM_W(PWM_W)
  ) dut (
    .bd_fclk0_125m (clk),
    .ext_rst_n     (rst_n),
    .cfg           (cfg),
    .act_evt       (act_evt),
    .pwm_duty      (pwm_duty),
    .tick          (tick),
    .led_out       (led_out)
  );

  // Three-channel copy so a channel code past the last channel is expressible.
  led_status_ctrl #(
    .NUM_CH(NUM_CH2), .PRESCALE(PRESCALE), .PER_W(PER_W),
    .DEF_HALF_PER(DEF_HALF_PER), .STRETCH_TICKS(STRETCH_TICKS), .PWM_W(PWM_W)
  ) dut2 (
    .bd_fclk0_125m (clk),
    .ext_rst_n     (rst_n),
    .cfg           (cfg2),
    .act_evt       (act_evt2),
    .pwm_duty      (pwm_duty2),
    .tick          (tick2),
    .led_out       (led_out2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts cycles and ticks since reset/config/event and
  // derives each LED from those counts.
  bit                model_ok = 1'b0;
  int                k;
  led_mode_t         m_mode [NUM_CH];
  int                m_half [NUM_CH];
  int                m_ticks [NUM_CH];
  bit                m_evt [NUM_CH];
  int                m_evt_ticks [NUM_CH];
  logic [NUM_CH-1:0] exp_led;
  logic              exp_tick;

  function automatic bit model_raw(input int c);
    int eff;
    eff = (m_half[c] == 0) ? 1 : m_half[c];
    case (m_mode[c])
      LED_ON:    return 1'b1;
      LED_BLINK: return ((m_ticks[c] / eff) % 2) == 1;
      LED_ACT:   return m_evt[c] && (m_evt_ticks[c] < STRETCH_TICKS);
      default:   return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin
    bit tick_now;
    bit pwm_on;
    int pwm_pos;
    if (!rst_n) begin
      model_ok = 1'b1;
      k        = 0;
      exp_led  = '0;
      exp_tick = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_mode[c] = LED_OFF;
        m_half[c] = DEF_HALF_PER;
        m_ticks[c] = 0;
        m_evt[c] = 1'b0;
        m_evt_ticks[c] = 0;
      end
    end else if (model_ok) begin
      tick_now = (k > 0) && (k % PRESCALE == 0);
      pwm_pos  = k % (2 ** PWM_W);
      pwm_on   = (pwm_pos < int'(pwm_duty)) || (int'(pwm_duty) == 2 ** PWM_W - 1);
      for (int c = 0; c < NUM_CH; c++) exp_led[c] = model_raw(c) && pwm_on;
      exp_tick = (k % PRESCALE) == PRESCALE - 1;
      for (int c = 0; c < NUM_CH; c++) begin
        if (cfg.cfg_wr && int'(cfg.cfg_ch) == c) begin
          m_mode[c] = cfg.cfg_mode;
          m_half[c] = int'(cfg.cfg_half_per);
          m_ticks[c] = 0;
          m_evt[c] = 1'b0;
          m_evt_ticks[c] = 0;
        end else begin
          if (m_mode[c] == LED_BLINK && tick_now) m_ticks[c]++;
          if (m_mode[c] == LED_ACT) begin
            if (act_evt[c]) begin
              m_evt[c] = 1'b1;
              m_evt_ticks[c] = 0;
            end else if (tick_now && m_evt[c]) begin
              m_evt_ticks[c]++;
            end
          end
        end
      end
      k++;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("model_led_out", 32'(led_out), 32'(exp_led));
      check("model_tick", 32'(tick), 32'(exp_tick));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int ch, input led_mode_t m, input int half);
    cfg.cfg_wr       = 1'b1;
    cfg.cfg_ch       = ch[1:0];
    cfg.cfg_mode     = m;
    cfg.cfg_half_per = half[PER_W-1:0];
    @(negedge clk);
    cfg.cfg_wr = 1'b0;
  endtask

  // Measures toggle spacing of one LED bit and checks up to three intervals.
  task automatic blink_intervals(input string name, input int bit_i, input int exp_gap, input int span);
    logic prev;
    int   last;
    int   n;
    prev = led_out[bit_i];
    last = -1;
    n    = 0;
    for (int j = 1; j <= span; j++) begin
      @(negedge clk);
      if (led_out[bit_i] !== prev) begin
        if (last >= 0 && n < 3) begin
          check(name, 32'(j - last), 32'(exp_gap));
          n++;
        end
        last = j;
        prev = led_out[bit_i];
      end
    end
    check({name, "_count"}, 32'(n), 32'd3);
  endtask

  int duty_tab [3] = '{0, 4, 15};
  int lit_tab  [3] = '{0, 4, 16};

  initial begin
    int first;
    int second;
    int hi;
    int lit;
    cfg.cfg_wr = 1'b0;  cfg.cfg_ch = '0;  cfg.cfg_mode = LED_OFF;  cfg.cfg_half_per = '0;
    cfg2.cfg_wr = 1'b0; cfg2.cfg_ch = '0; cfg2.cfg_mode = LED_OFF; cfg2.cfg_half_per = '0;

    // 1. Reset and tick cadence.
    cyc(3);
    check("reset_led_out", 32'(led_out), 32'd0);
    check("reset_tick", 32'(tick), 32'd0);
    rst_n = 1'b1;
    first = -1;
    second = -1;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (tick) begin
        if (first < 0) first = j;
        else if (second < 0) second = j;
      end
    end
    check("first_tick_delay", 32'(first), 32'd4);
    check("tick_spacing", 32'(second - first), 32'd4);

    // Write past the last channel of the 3-channel copy is dropped.
    cfg2.cfg_wr = 1'b1; cfg2.cfg_ch = 2'd3; cfg2.cfg_mode = LED_ON;
    @(negedge clk);
    cfg2.cfg_wr = 1'b0;
    cyc(4);
    check("oob_write_ignored", 32'(led_out2), 32'd0);
    cfg2.cfg_wr = 1'b1; cfg2.cfg_ch = 2'd2; cfg2.cfg_mode = LED_ON;
    @(negedge clk);
    cfg2.cfg_wr = 1'b0;
    cyc(3);
    check("inrange_write_ch2", 32'(led_out2), 32'b100);

    // 2. Blink ch1 with half-period 2 at full brightness.
    pwm_duty = 4'hF;
    wr(1, LED_BLINK, 2);
    blink_intervals("blink_half2_gap", 1, 8, 40);

    // 3. Activity on ch2: latency, stretch length, then a second pulse.
    wr(2, LED_ACT, 0);
    cyc(2);
    act_evt[2] = 1'b1;
    @(negedge clk);
    act_evt[2] = 1'b0;
    check("act_not_yet_lit", 32'(led_out[2]), 32'd0);
    @(negedge clk);
    check("act_lit", 32'(led_out[2]), 32'd1);
    hi = 1;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      hi += int'(led_out[2]);
    end
    check("act_stretch_len_17_to_20", 32'(hi >= 17 && hi <= 20), 32'd1);
    act_evt[2] = 1'b1;
    @(negedge clk);
    act_evt[2] = 1'b0;
    cyc(10);
    act_evt[2] = 1'b1;
    @(negedge clk);
    act_evt[2] = 1'b0;
    cyc(30);

    // 4. ch0 ON, brightness sweep over one 16-cycle PWM window.
    wr(0, LED_ON, 0);
    for (int d = 0; d < 3; d++) begin
      pwm_duty = PWM_W'(duty_tab[d]);
      cyc(3);
      lit = 0;
      repeat (16) begin
        @(negedge clk);
        lit += int'(led_out[0]);
      end
      check($sformatf("pwm_lit_duty%0d", duty_tab[d]), 32'(lit), 32'(lit_tab[d]));
    end

    // 5. Half-period 0 blinks as half-period 1; event coincident with a tick.
    pwm_duty = 4'hF;
    wr(3, LED_BLINK, 0);
    blink_intervals("blink_half0_gap", 3, 4, 24);
    for (int j = 0; j < 8 && (k % PRESCALE) != 0; j++) @(negedge clk);
    act_evt[2] = 1'b1;
    @(negedge clk);
    act_evt[2] = 1'b0;
    cyc(30);

    // 6. One-cycle reset mid-blink and mid-stretch.
    act_evt[2] = 1'b1;
    @(negedge clk);
    act_evt[2] = 1'b0;
    cyc(3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrun_reset_led_out", 32'(led_out), 32'd0);
    cyc(12);
    check("after_reset_modes_off", 32'(led_out), 32'd0);
    wr(1, LED_BLINK, 2);
    cyc(2);
    check("restart_phase0", 32'(led_out[1]), 32'd0);
    cyc(4);

    // Randomized traffic against the model.
    for (int j = 0; j < 2500; j++) begin
      if ($urandom_range(0, 19) == 0) begin
        cfg.cfg_wr       = 1'b1;
        cfg.cfg_ch       = 2'($urandom_range(0, 3));
        cfg.cfg_mode     = led_mode_t'(2'($urandom_range(0, 3)));
        cfg.cfg_half_per = PER_W'($urandom_range(0, 4));
      end else begin
        cfg.cfg_wr = 1'b0;
      end
      for (int c = 0; c < NUM_CH; c++)
        act_evt[c] = act_evt[c] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 199) == 0) pwm_duty = PWM_W'($urandom_range(0, 15));
      rst_n = ($urandom_range(0, 699) != 0);
      @(negedge clk);
    end
    cfg.cfg_wr = 1'b0;
    rst_n = 1'b1;
    act_evt = '0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
